// File: rtl/ysyx_22041405_ifu.sv
// ysyx_22041405_ifu: instruction fetch unit.
//   Owns the PC and issues single-beat reads to instruction memory. It presents
//   one instruction at a time to the decoder over a valid/ready handshake.
//   EXU redirects replace the PC, and any fetch already in flight is discarded.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   imem_req_valid/ready/addr       instruction memory read request (addr = pc)
//   imem_rsp_valid/data             read response, one pulse per accepted request
//   instr_valid/ready, instr,       instruction toward IDU
//   instr_pc
//   redirect_valid, redirect_pc     PC redirect from EXU (single-cycle pulse)
// Optional build macro YSYX_22041405_IFU_PERF_EN:
//   perf_fetch_cnt                  counts IDU handshakes
//   perf_stall_cnt                  counts cycles spent in REQ or WAIT
module ysyx_22041405_ifu #(
  parameter int unsigned WIDTH = 32,
  parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(32'h8000_0000)
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req_valid,
  input  logic             imem_req_ready,
  output logic [WIDTH-1:0] imem_req_addr,
  input  logic             imem_rsp_valid,
  input  logic [WIDTH-1:0] imem_rsp_data,
  output logic             instr_valid,
  input  logic             instr_ready,
  output logic [WIDTH-1:0] instr,
  output logic [WIDTH-1:0] instr_pc,
  input  logic             redirect_valid,
  input  logic [WIDTH-1:0] redirect_pc
`ifdef YSYX_22041405_IFU_PERF_EN
  ,
  output logic [63:0]      perf_fetch_cnt,
  output logic [63:0]      perf_stall_cnt
`endif
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    HOLD = 2'd3
  } state_t;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] pc, pc_nxt;
  logic             drop, drop_nxt;
  logic [WIDTH-1:0] instr_nxt, instr_pc_nxt;

  // Handshake strobes are decoded directly from the state register.
  assign imem_req_valid = (state == REQ);
  assign instr_valid    = (state == HOLD);
  assign imem_req_addr  = pc;

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      pc       <= RESET_PC;
      drop     <= 1'b0;
      instr    <= '0;
      instr_pc <= '0;
    end else begin
      state    <= state_nxt;
      pc       <= pc_nxt;
      drop     <= drop_nxt;
      instr    <= instr_nxt;
      instr_pc <= instr_pc_nxt;
    end
  end

  // Next-state logic; a redirect always takes priority over pc+4.
  always_comb begin
    state_nxt    = state;
    pc_nxt       = pc;
    drop_nxt     = drop;
    instr_nxt    = instr;
    instr_pc_nxt = instr_pc;
    case (state)
      IDLE: begin
        state_nxt = REQ;
        if (redirect_valid) pc_nxt = redirect_pc;
      end
      REQ: begin
        if (redirect_valid) pc_nxt = redirect_pc;
        if (imem_req_ready) begin
          state_nxt = WAIT;
          // The accepted request was for the old PC; its data must be dropped.
          if (redirect_valid) drop_nxt = 1'b1;
        end
      end
      WAIT: begin
        if (redirect_valid) begin
          pc_nxt = redirect_pc;
          if (imem_rsp_valid) begin
            drop_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            drop_nxt = 1'b1;
          end
        end else if (imem_rsp_valid) begin
          if (drop) begin
            drop_nxt  = 1'b0;
            state_nxt = REQ;
          end else begin
            instr_nxt    = imem_rsp_data;
            instr_pc_nxt = pc;
            state_nxt    = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_valid) begin
          pc_nxt    = redirect_pc;
          state_nxt = REQ;
        end else if (instr_ready) begin
          pc_nxt    = pc + WIDTH'(4);
          state_nxt = REQ;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

`ifdef YSYX_22041405_IFU_PERF_EN
  // Observation-only counters; they never feed back into the fetch logic.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_fetch_cnt <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (instr_valid && instr_ready) perf_fetch_cnt <= perf_fetch_cnt + 64'd1;
      if (state == REQ || state == WAIT) perf_stall_cnt <= perf_stall_cnt + 64'd1;
    end
  end
`endif

endmodule

// File: tb/tb_ysyx_22041405_ifu.sv
// tb_ysyx_22041405_ifu: directed self-checking bench for the fetch unit.
//   The bench plays instruction memory and IDU cycle by cycle. Every response it
//   expects to be delivered is queued, and it is popped when instr_valid shows up.
module tb_ysyx_22041405_ifu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
`ifdef YSYX_22041405_IFU_PERF_EN
  logic [63:0] perf_fetch_cnt;
  logic [63:0] perf_stall_cnt;
`endif

  ysyx_22041405_ifu dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
`ifdef YSYX_22041405_IFU_PERF_EN
    ,
    .perf_fetch_cnt (perf_fetch_cnt),
    .perf_stall_cnt (perf_stall_cnt)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
  } exp_t;

  exp_t sb[$];
  int   tests = 0;
  int   fails = 0;
  int   fetch_exp = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp)
    else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present a response for one cycle; it is expected to reach IDU.
  task automatic do_rsp(input logic [31:0] data, input logic [31:0] pc);
    exp_t e;
    e.data = data;
    e.pc   = pc;
    sb.push_back(e);
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = data;
    step();
    imem_rsp_valid = 1'b0;
  endtask

  // An instruction is on offer: compare it against the oldest queued response.
  task automatic chk_instr(input string tag);
    exp_t e;
    check({tag, "_valid"}, 64'(instr_valid), 64'(1'b1));
    check({tag, "_sb_nonempty"}, 64'(sb.size() != 0), 64'(1'b1));
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_instr"}, 64'(instr), 64'(e.data));
      check({tag, "_pc"}, 64'(instr_pc), 64'(e.pc));
    end
  endtask

  task automatic chk_perf(input string tag);
`ifdef YSYX_22041405_IFU_PERF_EN
    check({tag, "_fetch_cnt"}, perf_fetch_cnt, 64'(fetch_exp));
`else
    tests = tests + 0;
`endif
  endtask

  initial begin
    rst_n          = 1'b0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    instr_ready    = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    step();
    step();

    // Reset state.
    check("rst_req_valid", 64'(imem_req_valid), 64'(1'b0));
    check("rst_instr_valid", 64'(instr_valid), 64'(1'b0));
    check("rst_instr", 64'(instr), 64'(32'h0));
    check("rst_instr_pc", 64'(instr_pc), 64'(32'h0));
    check("rst_addr", 64'(imem_req_addr), 64'(32'h8000_0000));
`ifdef YSYX_22041405_IFU_PERF_EN
    check("rst_fetch_cnt", perf_fetch_cnt, 64'd0);
    check("rst_stall_cnt", perf_stall_cnt, 64'd0);
`endif

    // The first cycle after reset release is spent in IDLE.
    rst_n = 1'b1;
    check("idle_req_valid", 64'(imem_req_valid), 64'(1'b0));
    step();
    check("first_req_valid", 64'(imem_req_valid), 64'(1'b1));
    check("first_req_addr", 64'(imem_req_addr), 64'(32'h8000_0000));

    // Basic fetch with k=1 and IDU always ready.
    step();
    check("wait_req_valid", 64'(imem_req_valid), 64'(1'b0));
    check("wait_instr_valid", 64'(instr_valid), 64'(1'b0));
    instr_ready = 1'b1;
    do_rsp(32'h0010_0093, 32'h8000_0000);
    chk_instr("f0");
    step();
    fetch_exp++;
    check("f0_next_addr", 64'(imem_req_addr), 64'(32'h8000_0004));
    check("f0_next_req_valid", 64'(imem_req_valid), 64'(1'b1));
    check("f0_instr_pulse", 64'(instr_valid), 64'(1'b0));

    // IDU stalls for five cycles in HOLD.
    instr_ready = 1'b0;
    step();
    do_rsp(32'h0020_0113, 32'h8000_0004);
    chk_instr("f1");
    for (int i = 0; i < 5; i++) begin
      step();
      check("hold_valid", 64'(instr_valid), 64'(1'b1));
      check("hold_no_req", 64'(imem_req_valid), 64'(1'b0));
      check("hold_instr", 64'(instr), 64'(32'h0020_0113));
      check("hold_pc", 64'(instr_pc), 64'(32'h8000_0004));
    end
    instr_ready = 1'b1;
    step();
    fetch_exp++;
    instr_ready = 1'b0;
    check("f1_next_addr", 64'(imem_req_addr), 64'(32'h8000_0008));

    // Redirect while waiting; the late response must be dropped.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    step();
    redirect_valid = 1'b0;
    check("rw_still_wait", 64'(imem_req_valid), 64'(1'b0));
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hdead_beef;
    step();
    imem_rsp_valid = 1'b0;
    check("rw_no_instr", 64'(instr_valid), 64'(1'b0));
    check("rw_req_valid", 64'(imem_req_valid), 64'(1'b1));
    check("rw_addr", 64'(imem_req_addr), 64'(32'h8000_0100));

    // Redirect in HOLD together with instr_ready: handshake counts, target wins.
    step();
    do_rsp(32'h0030_0193, 32'h8000_0100);
    chk_instr("f2");
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0100;
    instr_ready    = 1'b1;
    step();
    fetch_exp++;
    redirect_valid = 1'b0;
    instr_ready    = 1'b0;
    check("rh_instr_valid", 64'(instr_valid), 64'(1'b0));
    check("rh_addr", 64'(imem_req_addr), 64'(32'h8000_0100));
    chk_perf("rh");

    // Unaccepted request: address stable, and a redirect replaces it.
    imem_req_ready = 1'b0;
    step();
    check("stall_addr", 64'(imem_req_addr), 64'(32'h8000_0100));
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0200;
    step();
    redirect_valid = 1'b0;
    check("rr_req_valid", 64'(imem_req_valid), 64'(1'b1));
    check("rr_addr", 64'(imem_req_addr), 64'(32'h8000_0200));
    step();
    check("rr_addr_stable", 64'(imem_req_addr), 64'(32'h8000_0200));

    // Redirect in the same cycle the request fires: that response is dropped.
    redirect_valid = 1'b1;
    redirect_pc    = 32'hffff_fffc;
    imem_req_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'hbad0_bad0;
    step();
    imem_rsp_valid = 1'b0;
    check("rf_no_instr", 64'(instr_valid), 64'(1'b0));
    check("rf_addr", 64'(imem_req_addr), 64'(32'hffff_fffc));

    // pc+4 wraps at the top of the address space.
    step();
    do_rsp(32'h0040_0213, 32'hffff_fffc);
    chk_instr("f3");
    instr_ready = 1'b1;
    step();
    fetch_exp++;
    instr_ready = 1'b0;
    check("wrap_addr", 64'(imem_req_addr), 64'(32'h0000_0000));

    // Redirect and response in the same WAIT cycle: dropped, no stale drop flag.
    step();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h8000_0040;
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h1111_1111;
    step();
    redirect_valid = 1'b0;
    imem_rsp_valid = 1'b0;
    check("rsw_no_instr", 64'(instr_valid), 64'(1'b0));
    check("rsw_addr", 64'(imem_req_addr), 64'(32'h8000_0040));
    step();
    do_rsp(32'h0050_0293, 32'h8000_0040);
    chk_instr("f4");
    instr_ready = 1'b1;
    step();
    fetch_exp++;
    instr_ready = 1'b0;
    check("f4_next_addr", 64'(imem_req_addr), 64'(32'h8000_0044));
    chk_perf("f4");

    // Reset asserted during WAIT takes effect at once.
    step();
    rst_n = 1'b0;
    #1;
    check("mrst_req_valid", 64'(imem_req_valid), 64'(1'b0));
    check("mrst_instr_valid", 64'(instr_valid), 64'(1'b0));
    check("mrst_addr", 64'(imem_req_addr), 64'(32'h8000_0000));
    fetch_exp = 0;
    chk_perf("mrst");
    step();
    rst_n = 1'b1;
    // Stale response from the aborted request arrives in IDLE and is ignored.
    imem_rsp_valid = 1'b1;
    imem_rsp_data  = 32'h2222_2222;
    step();
    imem_rsp_valid = 1'b0;
    check("stale_no_instr", 64'(instr_valid), 64'(1'b0));
    check("refetch_req_valid", 64'(imem_req_valid), 64'(1'b1));
    check("refetch_addr", 64'(imem_req_addr), 64'(32'h8000_0000));
    step();
    do_rsp(32'h0010_0093, 32'h8000_0000);
    chk_instr("f5");
    instr_ready = 1'b1;
    step();
    fetch_exp++;
    instr_ready = 1'b0;
    check("f5_next_addr", 64'(imem_req_addr), 64'(32'h8000_0004));
    chk_perf("f5");
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
